// File: rtl/rib_arbiter_pkg.sv
// Shared constants for the RIB arbiter: hold codes, master indices, FSM states.
// Hold codes are ordered so that a larger value freezes more of the pipeline.
package rib_arbiter_pkg;

    localparam int N_MASTERS = 3;

    localparam logic [2:0] HOLD_NONE  = 3'd0;
    localparam logic [2:0] HOLD_PC    = 3'd1;
    localparam logic [2:0] HOLD_IF_ID = 3'd2;
    localparam logic [2:0] HOLD_ID_EX = 3'd3;

    localparam logic [1:0] RIB_M_EX = 2'd0;
    localparam logic [1:0] RIB_M_ID = 2'd1;
    localparam logic [1:0] RIB_M_IF = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // The highest-priority waiting master sets the deepest stall.
    function automatic logic [2:0] hold_code(input logic [2:0] waiting);
        if (waiting[RIB_M_EX])      return HOLD_ID_EX;
        else if (waiting[RIB_M_ID]) return HOLD_IF_ID;
        else if (waiting[RIB_M_IF]) return HOLD_PC;
        else                        return HOLD_NONE;
    endfunction

endpackage

// File: rtl/rib_arbiter_if.sv
// RIB arbiter bus bundle: three master request/response ports, the slave port and pipeline status.
// Modport master is the arbiter's view (it masters the slave bus); slave is the surrounding core's view.
interface rib_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]          m_req_i;
    logic [2:0]          m_we_i;
    logic [3*ADDR_W-1:0] m_addr_i;
    logic [3*DATA_W-1:0] m_wdata_i;
    logic [2:0]          m_ack_o;
    logic [2:0]          m_err_o;
    logic [DATA_W-1:0]   m_rdata_o;
    logic                s_req_o;
    logic                s_we_o;
    logic [ADDR_W-1:0]   s_addr_o;
    logic [DATA_W-1:0]   s_wdata_o;
    logic                s_ack_i;
    logic [DATA_W-1:0]   s_rdata_i;
    logic [2:0]          grant_o;
    logic [2:0]          hold_flag_o;

    modport master (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
        output m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
               grant_o, hold_flag_o
    );

    modport slave (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i, s_ack_i, s_rdata_i,
        input  m_ack_o, m_err_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
               grant_o, hold_flag_o
    );
endinterface

// File: rtl/rib_arb_pick.sv
// Combinational winner search over three requests starting at i_start and wrapping.
// Zero latency; no backpressure, o_vld is low when nothing requests.
module rib_arb_pick (
    input  logic [2:0] i_req,
    input  logic [1:0] i_start,
    output logic [2:0] o_onehot,
    output logic [1:0] o_idx,
    output logic       o_vld
);
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_vld    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!o_vld && i_req[(int'(i_start) + k) % 3]) begin
                o_vld                                 = 1'b1;
                o_idx                                 = 2'((int'(i_start) + k) % 3);
                o_onehot[(int'(i_start) + k) % 3]     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rib_arbiter.sv
// Three-master RIB arbiter: one transaction at a time, IDLE->BUSY->RESP, plus pipeline hold code.
// Latency: request to s_req_o 1 cycle, s_ack_i to m_ack_o 1 cycle; masters hold requests until ack/err.
// RIB_ARB_RR_EN selects round-robin arbitration instead of fixed priority 0>1>2.
module rib_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          rst,
    rib_arbiter_if.master bus
);
    import rib_arbiter_pkg::*;

    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [2:0]        r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_pick_onehot;
    logic [1:0]        w_pick_idx;
    logic              w_pick_vld;
    logic [1:0]        w_start;
    logic              w_timeout;
    logic              w_busy;
    logic              w_resp;
    logic [2:0]        w_ack;
    logic [2:0]        w_err;

`ifdef RIB_ARB_RR_EN
    logic [1:0] r_last;

    // Pointer resets to m2 so the very first search begins at m0.
    assign w_start = (r_last == RIB_M_IF) ? RIB_M_EX : r_last + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= RIB_M_IF;
        else if (r_state == ARB_IDLE && w_pick_vld)
            r_last <= w_pick_idx;
    end
`else
    assign w_start = RIB_M_EX;
`endif

    rib_arb_pick u_pick (
        .i_req    (bus.m_req_i),
        .i_start  (w_start),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TO_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ARB_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: if (w_pick_vld) w_state_nxt = ARB_BUSY;
            ARB_BUSY: if (bus.s_ack_i || w_timeout) w_state_nxt = ARB_RESP;
            ARB_RESP: w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant <= w_pick_onehot;
                        r_we    <= bus.m_we_i[w_pick_idx];
                        r_addr  <= bus.m_addr_i[w_pick_idx*ADDR_W +: ADDR_W];
                        r_wdata <= bus.m_wdata_i[w_pick_idx*DATA_W +: DATA_W];
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                ARB_BUSY: begin
                    // Ack takes precedence over a timeout landing in the same cycle.
                    if (bus.s_ack_i) begin
                        r_rdata <= bus.s_rdata_i;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_busy = (r_state == ARB_BUSY);
    assign w_resp = (r_state == ARB_RESP);
    assign w_ack  = (w_resp && !r_err) ? r_grant : 3'b000;
    assign w_err  = (w_resp &&  r_err) ? r_grant : 3'b000;

    assign bus.s_req_o     = w_busy;
    assign bus.s_we_o      = w_busy & r_we;
    assign bus.s_addr_o    = w_busy ? r_addr  : '0;
    assign bus.s_wdata_o   = w_busy ? r_wdata : '0;
    assign bus.grant_o     = (r_state == ARB_IDLE) ? 3'b000 : r_grant;
    assign bus.m_ack_o     = w_ack;
    assign bus.m_err_o     = w_err;
    assign bus.m_rdata_o   = w_resp && !r_err ? r_rdata : '0;
    assign bus.hold_flag_o = rst ? HOLD_NONE : hold_code(bus.m_req_i & ~(w_ack | w_err));

endmodule
